dual_port_fill_verify: RTL

- Downstream consumer of the even/odd address-pair stream used by the draw path.
- Takes a pair range (base pair index, pair count) and writes two colour words per cycle into a dual-port framebuffer RAM: port A at even addresses, port B at odd addresses.
- Optionally reads the range back through both ports, compares it against the written colours, and reports an error count and a pass flag.
- Sits between the draw control logic and the dual-port framebuffer.

---
 rtl/dual_port_fill_verify.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dual_port_fill_verify.sv
// Fills a pair range of a dual-port framebuffer (A=even, B=odd words), then optionally
// reads it back through both ports and counts mismatching words.
module dual_port_fill_verify #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-2:0] base_pair,
   input  logic [ADDR_W-1:0] num_pairs,
   input  logic [DATA_W-1:0] color_a,
   input  logic [DATA_W-1:0] color_b,
   input  logic              verify_en,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] wdata_a,
   output logic [DATA_W-1:0] wdata_b,
   output logic              we_a,
   output logic              we_b,
   input  logic [DATA_W-1:0] rdata_a,
   input  logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] err_cnt,
   output logic              pass
);

   localparam int PW = ADDR_W - 1;
   localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
   localparam logic [1:0]        DRAIN_LD = 2'(RD_LAT - 1);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [PW-1:0]     ptr;
   logic [ADDR_W-1:0] cnt;
   logic [PW-1:0]     lat_base;
   logic [ADDR_W-1:0] lat_num;
   logic [DATA_W-1:0] lat_ca;
   logic [DATA_W-1:0] lat_cb;
   logic              lat_ver;
   logic              rd_vld;
   logic [RD_LAT-1:0] vld_sr;
   logic [1:0]        drain;

   logic [1:0]        mism;
   logic [ADDR_W:0]   err_sum;
   logic [ADDR_W-1:0] err_next;
   logic [PW-1:0]     ptr_inc;
   logic              last_pair;

   // A compare lands when the flag issued with a read address reaches the end of the delay line.
   always_comb begin
      mism = 2'd0;
      if (vld_sr[RD_LAT-1]) begin
         mism = 2'(rdata_a != lat_ca) + 2'(rdata_b != lat_cb);
      end
      err_sum   = {1'b0, err_cnt} + {{(ADDR_W-1){1'b0}}, mism};
      err_next  = err_sum[ADDR_W] ? {ADDR_W{1'b1}} : err_sum[ADDR_W-1:0];
      ptr_inc   = ptr + PTR_ONE;
      last_pair = (cnt == lat_num - CNT_ONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         lat_base <= '0;
         lat_num  <= '0;
         lat_ca   <= '0;
         lat_cb   <= '0;
         lat_ver  <= 1'b0;
         rd_vld   <= 1'b0;
         vld_sr   <= '0;
         drain    <= '0;
         addr_a   <= '0;
         addr_b   <= '0;
         wdata_a  <= '0;
         wdata_b  <= '0;
         we_a     <= 1'b0;
         we_b     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_cnt  <= '0;
         pass     <= 1'b0;
      end else begin
         done      <= 1'b0;
         err_cnt   <= err_next;
         vld_sr[0] <= rd_vld;
         for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];

         case (state)
            IDLE: begin
               if (start) begin
                  lat_base <= base_pair;
                  lat_num  <= num_pairs;
                  lat_ca   <= color_a;
                  lat_cb   <= color_b;
                  lat_ver  <= verify_en;
                  wdata_a  <= color_a;
                  wdata_b  <= color_b;
                  err_cnt  <= '0;
                  pass     <= 1'b0;
                  busy     <= 1'b1;
                  ptr      <= base_pair;
                  cnt      <= '0;
                  if (num_pairs == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state  <= WRITE;
                     we_a   <= 1'b1;
                     we_b   <= 1'b1;
                     addr_a <= {base_pair, 1'b0};
                     addr_b <= {base_pair, 1'b1};
                  end
               end
            end
            WRITE: begin
               if (last_pair) begin
                  we_a <= 1'b0;
                  we_b <= 1'b0;
                  ptr  <= lat_base;
                  cnt  <= '0;
                  if (lat_ver) begin
                     state  <= READ;
                     rd_vld <= 1'b1;
                     addr_a <= {lat_base, 1'b0};
                     addr_b <= {lat_base, 1'b1};
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  ptr    <= ptr_inc;
                  cnt    <= cnt + CNT_ONE;
                  addr_a <= {ptr_inc, 1'b0};
                  addr_b <= {ptr_inc, 1'b1};
               end
            end
            READ: begin
               if (last_pair) begin
                  rd_vld <= 1'b0;
                  drain  <= DRAIN_LD;
                  state  <= DRAIN;
               end else begin
                  ptr    <= ptr_inc;
                  cnt    <= cnt + CNT_ONE;
                  addr_a <= {ptr_inc, 1'b0};
                  addr_b <= {ptr_inc, 1'b1};
               end
            end
            DRAIN: begin
               if (drain == 2'd0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  drain <= drain - 2'd1;
               end
            end
            DONE: begin
               pass  <= (err_next == '0);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
